// File: rtl/uart_imem_loader.sv
// UART boot loader for the Mini-RISC-V instruction memory: receives 8N1 bytes while
// prog is high, packs them into words and writes them to imem at incrementing addresses.
module uart_imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter bit          BIG_ENDIAN   = 1'b0,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    Rst_n,
  input  logic                    rx,
  input  logic                    prog,
  output logic                    imem_prog_ena,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [8*WORD_BYTES-1:0] imem_din,
  output logic [ADDR_W:0]         word_cnt,
  output logic                    frame_err,
  output logic                    addr_wrap
);

  localparam int unsigned DW     = 8 * WORD_BYTES;
  localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic              rx_meta_q, rx_sync_q;
  logic              prog_q;
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [DW-1:0]     word_q, word_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     din_q, din_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ferr_q, ferr_d;
  logic              wrap_q, wrap_d;

  logic              byte_ok;
  logic [IDX_W-1:0]  lane;

  assign lane = BIG_ENDIAN ? (IDX_LAST - byte_idx_q) : byte_idx_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    to_cnt_d   = to_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    ferr_d     = ferr_q;
    wrap_d     = wrap_q;
    byte_ok    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_START;
          tmr_d   = '0;
        end
      end
      S_START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
          if (rx_sync_q) byte_ok = 1'b1;
          else           ferr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_ok) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane == IDX_W'(i)) word_d[8*i +: 8] = shift_q;
      end
      if (byte_idx_q == IDX_LAST) begin
        byte_idx_d = '0;
        din_d      = word_d;
        // The write is squashed if prog drops in the same cycle the word completes.
        we_d       = prog;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end

    // A partial word left sitting in IDLE too long is discarded.
    if (state_q == S_IDLE && byte_idx_q != '0) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        byte_idx_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end

    if (we_q) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == '1) wrap_d = 1'b1;
      if (cnt_q != '1)  cnt_d  = cnt_q + 1'b1;
    end

    if (!prog_q) begin
      state_d    = S_IDLE;
      tmr_d      = '0;
      bit_cnt_d  = '0;
      byte_idx_d = '0;
      to_cnt_d   = '0;
      we_d       = 1'b0;
    end

    if (prog && !prog_q) begin
      addr_d = '0;
      cnt_d  = '0;
      ferr_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the synchroniser resets to the idle-high line level so reset release never looks like a start bit.
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      prog_q     <= 1'b0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      to_cnt_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      ferr_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      prog_q     <= prog;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      to_cnt_q   <= to_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      ferr_q     <= ferr_d;
      wrap_q     <= wrap_d;
    end
  end

  assign imem_prog_ena = prog_q;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_din      = din_q;
  assign word_cnt      = cnt_q;
  assign frame_err     = ferr_q;
  assign addr_wrap     = wrap_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: little- and big-endian instances share one serial stream
// and are checked against a byte-queue model of the expected imem writes.
module tb_uart_imem_loader;

  localparam int CPB = 16;
  localparam int WB  = 4;
  localparam int AW  = 4;
  localparam int TOB = 4;

  logic clk = 1'b0;
  logic Rst_n, rx, prog;

  logic          le_ena, le_we, le_ferr, le_wrap;
  logic [AW-1:0] le_addr;
  logic [31:0]   le_din;
  logic [AW:0]   le_cnt;
  logic          be_ena, be_we, be_ferr, be_wrap;
  logic [AW-1:0] be_addr;
  logic [31:0]   be_din;
  logic [AW:0]   be_cnt;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .ADDR_W(AW),
                     .BIG_ENDIAN(1'b0), .TIMEOUT_BITS(TOB)) dut_le (
    .clk(clk), .Rst_n(Rst_n), .rx(rx), .prog(prog),
    .imem_prog_ena(le_ena), .imem_we(le_we), .imem_addr(le_addr), .imem_din(le_din),
    .word_cnt(le_cnt), .frame_err(le_ferr), .addr_wrap(le_wrap));

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .ADDR_W(AW),
                     .BIG_ENDIAN(1'b1), .TIMEOUT_BITS(TOB)) dut_be (
    .clk(clk), .Rst_n(Rst_n), .rx(rx), .prog(prog),
    .imem_prog_ena(be_ena), .imem_we(be_we), .imem_addr(be_addr), .imem_din(be_din),
    .word_cnt(be_cnt), .frame_err(be_ferr), .addr_wrap(be_wrap));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din_le;
    logic [31:0]   din_be;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] m_bytes[$];
  int         m_addr, m_cnt;
  bit         m_ferr, m_wrap, m_prog;
  logic       exp_ena;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0]   last_le, last_be;
  logic [AW-1:0] last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: accepted bytes queue up until a word is complete, then one write is expected.
  task automatic model_byte(input logic [7:0] b, input logic stop);
    wr_t w;
    if (!m_prog) return;
    if (!stop) begin
      m_ferr = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == WB) begin
      w.addr   = AW'(m_addr);
      w.din_le = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      w.din_be = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      exp_q.push_back(w);
      m_bytes.delete();
      if (m_addr == (1 << AW) - 1) begin
        m_addr = 0;
        m_wrap = 1'b1;
      end else begin
        m_addr++;
      end
      if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
    end
  endtask

  always @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) exp_ena <= 1'b0;
    else        exp_ena <= prog;
  end

  always @(negedge clk) begin : compare
    wr_t w;
    check("prog_ena_le", le_ena, exp_ena);
    check("prog_ena_be", be_ena, exp_ena);
    if (le_we || be_we) begin
      check("we_pair", {le_we, be_we}, 2'b11);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, none pending (t=%0t)",
                 le_addr, le_din, $time);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr_le", le_addr, w.addr);
        check("wr_addr_be", be_addr, w.addr);
        check("wr_din_le", le_din, w.din_le);
        check("wr_din_be", be_din, w.din_be);
      end
      last_le   = le_din;
      last_be   = be_din;
      last_addr = le_addr;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    model_byte(b, stop);
    drive_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    if (n >= 80) m_bytes.delete();
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_prog(input logic v);
    if (v && !m_prog) begin
      m_addr = 0;
      m_cnt  = 0;
      m_ferr = 1'b0;
      m_wrap = 1'b0;
      m_bytes.delete();
    end
    if (!v) m_bytes.delete();
    m_prog = v;
    prog   = v;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_addr_le"}, le_addr, m_addr);
    check({tag, "_addr_be"}, be_addr, m_addr);
    check({tag, "_cnt_le"}, le_cnt, m_cnt);
    check({tag, "_cnt_be"}, be_cnt, m_cnt);
    check({tag, "_ferr_le"}, le_ferr, m_ferr);
    check({tag, "_ferr_be"}, be_ferr, m_ferr);
    check({tag, "_wrap_le"}, le_wrap, m_wrap);
    check({tag, "_wrap_be"}, be_wrap, m_wrap);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_le"}, {le_ena, le_we, le_addr, le_din, le_cnt, le_ferr, le_wrap}, '0);
    check({tag, "_be"}, {be_ena, be_we, be_addr, be_din, be_cnt, be_ferr, be_wrap}, '0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx = 1'b1; prog = 1'b0; Rst_n = 1'b0;
    m_addr = 0; m_cnt = 0; m_ferr = 1'b0; m_wrap = 1'b0; m_prog = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    Rst_n = 1'b1;
    idle(3);
    check_status("idle");
    set_prog(1'b1);
    idle(3);

    // 1: single little-endian word
    send_word(32'h0010_0513);
    wait_drained();
    check("t1_din_le", last_le, 32'h0010_0513);
    check("t1_din_be", last_be, 32'h1305_1000);
    check("t1_addr", last_addr, 4'd0);
    check("t1_cnt", le_cnt, 5'd1);
    check_status("t1");

    // 2: following words land at consecutive addresses
    send_word(32'hDEAD_BEEF);
    wait_drained();
    send_word(32'h0123_4567);
    wait_drained();
    check("t2_addr", last_addr, 4'd2);
    check("t2_din_be", last_be, 32'h6745_2301);
    check("t2_next_addr", le_addr, 4'd3);
    check_status("t2");

    // 3: new session, 17 words wrap the 16-word address space
    set_prog(1'b0);
    idle(3);
    set_prog(1'b1);
    idle(3);
    check_status("t3_clear");
    for (int i = 0; i < 17; i++) begin
      send_word({8'(i), 8'hA5, 8'(i * 3), 8'h5A});
      wait_drained();
    end
    check("t3_wrap", le_wrap, 1'b1);
    check("t3_cnt", le_cnt, 5'd17);
    check("t3_last_addr", last_addr, 4'd0);
    check("t3_din_le", last_le, 32'h10A5_305A);
    check_status("t3");

    // 4: a byte with a bad stop bit is skipped in packing
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(24);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_drained();
    check("t4_din_le", last_le, 32'h5544_3311);
    check("t4_ferr", le_ferr, 1'b1);
    check_status("t4");

    // 5: short glitch yields nothing; stale partial word times out
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check_status("t5_glitch");
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    idle(100);
    send_word(32'hCAFE_F00D);
    wait_drained();
    check("t5_din_le", last_le, 32'hCAFE_F00D);
    check("t5_addr", last_addr, 4'd2);
    check_status("t5");

    // 6: asynchronous reset mid-byte, then prog toggle mid-word
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    Rst_n = 1'b0;
    #1;
    check_zero("t6_reset");
    m_addr = 0; m_cnt = 0; m_ferr = 1'b0; m_wrap = 1'b0;
    m_bytes.delete();
    exp_q.delete();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    Rst_n = 1'b1;
    idle(4);
    check_status("t6_after_reset");
    send_word(32'h1122_3344);
    wait_drained();
    send_byte(8'h99, 1'b0);
    idle(24);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    set_prog(1'b0);
    idle(4);
    check_status("t6_hold");
    check("t6_hold_cnt", le_cnt, 5'd1);
    send_word(32'h5555_5555);
    idle(4);
    check_status("t6_ignored");
    set_prog(1'b1);
    idle(4);
    check_status("t6_session");
    send_word(32'h0BAD_F00D);
    wait_drained();
    check("t6_addr", last_addr, 4'd0);
    check("t6_din_le", last_le, 32'h0BAD_F00D);
    check_status("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
